// File: rtl/current_mirror_cfg_ctrl.sv
// Soft-start/soft-stop sequencer and round-robin reconfiguration arbiter for the 2-bit current mirror code.
// Optional macro CM_CTRL_STAT_EN adds the reconf_cnt statistics output.
module current_mirror_cfg_ctrl #(
    parameter int          HOLD_CYC     = 16,
    parameter int          CNT_W        = 8,
    parameter logic [1:0]  DEFAULT_CODE = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] req_code0,
    input  logic [1:0] req_code1,
    output logic [1:0] gnt,
    output logic [1:0] cfg_mirr,
    output logic       busy,
    output logic       settled,
    output logic       done
`ifdef CM_CTRL_STAT_EN
    ,
    output logic [7:0] reconf_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RAMP    = 2'd1,
        ST_RAMPDN  = 2'd2,
        ST_SETTLED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYC - 1);

    state_t           state_r, state_s;
    logic [1:0]       cfg_r, cfg_s;
    logic [1:0]       tgt_r, tgt_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ptr_r, ptr_s;
    logic             pend_r, pend_s;
    logic [1:0]       gnt_r, gnt_s;
    logic             done_r, done_s;
    logic             busy_r, settled_r;
    logic             win_s;
    logic [1:0]       win_code_s;

    // Next-state, dwell timing, stepping and arbitration
    always_comb begin
        state_s    = state_r;
        cfg_s      = cfg_r;
        tgt_s      = tgt_r;
        cnt_s      = cnt_r;
        ptr_s      = ptr_r;
        pend_s     = 1'b0;
        gnt_s      = 2'b00;
        done_s     = 1'b0;
        win_s      = (req[0] && (!req[1] || !ptr_r)) ? 1'b0 : 1'b1;
        win_code_s = win_s ? req_code1 : req_code0;
        case (state_r)
            ST_OFF: begin
                cnt_s = {CNT_W{1'b0}};
                if (en) begin
                    state_s = ST_RAMP;
                    tgt_s   = DEFAULT_CODE;
                end else begin
                    tgt_s   = 2'b00;
                end
            end
            ST_RAMP, ST_RAMPDN: begin
                if ((state_r == ST_RAMP) && !en) begin
                    state_s = ST_RAMPDN;
                    tgt_s   = 2'b00;
                    cnt_s   = {CNT_W{1'b0}};
                end else if ((state_r == ST_RAMPDN) && en) begin
                    state_s = ST_RAMP;
                    tgt_s   = DEFAULT_CODE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == LAST_CNT) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (cfg_r != tgt_r) begin
                        cfg_s = (cfg_r < tgt_r) ? cfg_r + 2'd1 : cfg_r - 2'd1;
                    end else if (state_r == ST_RAMP) begin
                        state_s = ST_SETTLED;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_OFF;
                    end
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SETTLED: begin
                if (!en) begin
                    state_s = ST_RAMPDN;
                    tgt_s   = 2'b00;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (pend_r) begin
                    // same-code grant completes one cycle later, never alongside a grant
                    done_s = 1'b1;
                end else if (req != 2'b00) begin
                    gnt_s = win_s ? 2'b10 : 2'b01;
                    ptr_s = ~win_s;
                    tgt_s = win_code_s;
                    if (win_code_s != cfg_r) begin
                        state_s = ST_RAMP;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        pend_s  = 1'b1;
                    end
                end else begin
                    pend_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_OFF;
                cfg_s   = 2'b00;
                tgt_s   = 2'b00;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_OFF;
            cfg_r     <= 2'b00;
            tgt_r     <= 2'b00;
            cnt_r     <= {CNT_W{1'b0}};
            ptr_r     <= 1'b0;
            pend_r    <= 1'b0;
            gnt_r     <= 2'b00;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            settled_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cfg_r     <= cfg_s;
            tgt_r     <= tgt_s;
            cnt_r     <= cnt_s;
            ptr_r     <= ptr_s;
            pend_r    <= pend_s;
            gnt_r     <= gnt_s;
            done_r    <= done_s;
            busy_r    <= (state_s == ST_RAMP) || (state_s == ST_RAMPDN);
            settled_r <= (state_s == ST_SETTLED);
        end
    end

`ifdef CM_CTRL_STAT_EN
    logic [7:0] reconf_cnt_r;

    // A grant that leaves SETTLED for RAMP is exactly a grant with a differing code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reconf_cnt_r <= 8'd0;
        end else if ((gnt_s != 2'b00) && (state_s == ST_RAMP) && (reconf_cnt_r != 8'hFF)) begin
            reconf_cnt_r <= reconf_cnt_r + 8'd1;
        end else begin
            reconf_cnt_r <= reconf_cnt_r;
        end
    end

    assign reconf_cnt = reconf_cnt_r;
`endif

    assign gnt      = gnt_r;
    assign cfg_mirr = cfg_r;
    assign busy     = busy_r;
    assign settled  = settled_r;
    assign done     = done_r;

endmodule

// File: tb/tb_current_mirror_cfg_ctrl.sv
// Randomized bench for current_mirror_cfg_ctrl against a countdown-based behavioural model.
module tb_current_mirror_cfg_ctrl;

    localparam int HOLD = 16;
    localparam int DEF  = 1;
    localparam int M_OFF = 0, M_UP = 1, M_DOWN = 2, M_SET = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] req_code0 = 2'b00;
    logic [1:0] req_code1 = 2'b00;
    logic [1:0] gnt;
    logic [1:0] cfg_mirr;
    logic       busy;
    logic       settled;
    logic       done;
`ifdef CM_CTRL_STAT_EN
    logic [7:0] reconf_cnt;
`endif

    current_mirror_cfg_ctrl #(.HOLD_CYC(HOLD), .CNT_W(8), .DEFAULT_CODE(2'b01)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_code0(req_code0), .req_code1(req_code1),
        .gnt(gnt), .cfg_mirr(cfg_mirr), .busy(busy), .settled(settled), .done(done)
`ifdef CM_CTRL_STAT_EN
        , .reconf_cnt(reconf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state: mode, current code, goal, cycles left in the dwell, favoured requester
    int m_mode, m_code, m_tgt, m_left, m_ptr, m_pend, m_stat;
    int e_gnt, e_done;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_code = 0; m_tgt = 0; m_left = 0;
        m_ptr = 0; m_pend = 0; m_stat = 0; e_gnt = 0; e_done = 0;
    endtask

    task automatic model_step(input logic s_en, input logic [1:0] s_req, input int c0, input int c1);
        int win, t;
        e_gnt = 0;
        e_done = 0;
        if (m_mode == M_OFF) begin
            if (s_en) begin m_mode = M_UP; m_tgt = DEF; m_left = HOLD; end
        end else if (m_mode == M_UP && !s_en) begin
            m_mode = M_DOWN; m_tgt = 0; m_left = HOLD;
        end else if (m_mode == M_DOWN && s_en) begin
            m_mode = M_UP; m_tgt = DEF; m_left = HOLD;
        end else if (m_mode == M_UP || m_mode == M_DOWN) begin
            m_left--;
            if (m_left == 0) begin
                m_left = HOLD;
                if (m_code != m_tgt) m_code += (m_tgt > m_code) ? 1 : -1;
                else if (m_mode == M_UP) begin m_mode = M_SET; e_done = 1; end
                else m_mode = M_OFF;
            end
        end else begin
            if (!s_en) begin
                m_mode = M_DOWN; m_tgt = 0; m_left = HOLD; m_pend = 0;
            end else if (m_pend != 0) begin
                e_done = 1; m_pend = 0;
            end else if (s_req != 2'b00) begin
                win = (s_req == 2'b11) ? m_ptr : (s_req[1] ? 1 : 0);
                m_ptr = 1 - win;
                t = (win == 1) ? c1 : c0;
                e_gnt = 1 << win;
                m_tgt = t;
                if (t != m_code) begin
                    m_mode = M_UP; m_left = HOLD;
                    if (m_stat < 255) m_stat++;
                end else begin
                    m_pend = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, "_cfg"}, 8'(cfg_mirr), 8'(m_code));
        check_eq({ph, "_gnt"}, 8'(gnt), 8'(e_gnt));
        check_eq({ph, "_done"}, 8'(done), 8'(e_done));
        check_eq({ph, "_busy"}, 8'(busy), 8'((m_mode == M_UP || m_mode == M_DOWN) ? 1 : 0));
        check_eq({ph, "_settled"}, 8'(settled), 8'((m_mode == M_SET) ? 1 : 0));
`ifdef CM_CTRL_STAT_EN
        check_eq({ph, "_stat"}, reconf_cnt, 8'(m_stat));
`endif
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        for (int i = 1; i <= 20000; i++) begin
            // power-up window: en held high from edge 1, no requests
            if (i <= 40) begin
                en = 1'b1;
            end else begin
                if (en && $urandom_range(0, 249) == 0) en = 1'b0;
                else if (!en && $urandom_range(0, 59) == 0) en = 1'b1;
                if (!req[0] && $urandom_range(0, 29) == 0) begin
                    req[0] = 1'b1; req_code0 = 2'($urandom_range(0, 3));
                end
                if (!req[1] && $urandom_range(0, 29) == 0) begin
                    req[1] = 1'b1; req_code1 = 2'($urandom_range(0, 3));
                end
            end
            @(posedge clk);
            model_step(en, req, int'(req_code0), int'(req_code1));
            @(negedge clk);
            check_all("rand");
            if (i <= 33) begin
                check_eq("pu_cfg", 8'(cfg_mirr), (i >= 17) ? 8'd1 : 8'd0);
                check_eq("pu_busy", 8'(busy), (i >= 1 && i <= 32) ? 8'd1 : 8'd0);
                check_eq("pu_done", 8'(done), (i == 33) ? 8'd1 : 8'd0);
                check_eq("pu_settled", 8'(settled), (i == 33) ? 8'd1 : 8'd0);
            end
            if (e_gnt[0]) req[0] = 1'b0;
            if (e_gnt[1]) req[1] = 1'b0;
            // occasional asynchronous reset between edges
            if (i > 40 && $urandom_range(0, 999) == 0) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_eq("arst_cfg", 8'(cfg_mirr), 8'd0);
                check_eq("arst_busy", 8'(busy), 8'd0);
                check_eq("arst_settled", 8'(settled), 8'd0);
`ifdef CM_CTRL_STAT_EN
                check_eq("arst_stat", reconf_cnt, 8'd0);
`endif
                rst = 1'b0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/current_mirror_cfg_ctrl.md
Name: current_mirror_cfg_ctrl

Overview:
Sequencer and arbiter for the 2-bit mirror configuration code (cfg_mirr) of the current mirror array.
- Soft-starts the mirror from code 00 to a default code on enable and soft-stops it back to 00 on disable.
- Steps the code by ±1 with a programmable dwell per step, so the mirrored output current never jumps more than one weight at a time.
- Shares reconfiguration between two requesters using round-robin arbitration.

Parameters:
HOLD_CYC, 16, dwell in clock cycles per code step and final settle dwell (≥2)
CNT_W, 8, dwell counter width; requires HOLD_CYC ≤ 2^CNT_W
DEFAULT_CODE, 2'b01, target code applied on enable (nominal mirror current)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
en  input  1  level enable of the mirror bias
req  input  2  reconfiguration request per requester; held high until granted
req_code0  input  2  target code from requester 0, valid while req[0]=1
req_code1  input  2  target code from requester 1, valid while req[1]=1
gnt  output  2  one-cycle grant pulse, one-hot or zero
cfg_mirr  output  2  mirror configuration code driven to the current mirror
busy  output  1  high in RAMP and RAMPDN
settled  output  1  high in SETTLED only
done  output  1  one-cycle pulse on entering SETTLED

Behaviour:
Reset (async, immediate):
- state=OFF; cfg_mirr=00; gnt=00; busy=0; settled=0; done=0.
- Dwell counter=0; round-robin pointer favours requester 0.

All outputs are registered.

States:
- OFF:
  - cfg_mirr=00.
  - en=1 sampled → target=DEFAULT_CODE, go to RAMP, counter cleared.
- RAMP / RAMPDN:
  - Counter increments each cycle.
  - When counter==HOLD_CYC-1 and cfg_mirr≠target: next edge steps cfg_mirr by +1 or -1 toward target and clears the counter.
  - When counter==HOLD_CYC-1 and cfg_mirr==target:
    - RAMP → SETTLED, with done=1 for that one cycle.
    - RAMPDN → OFF.
  - Reaching the target therefore always costs one extra full dwell for settling.
- SETTLED:
  - Arbitrates req.
  - Winner gets gnt for exactly one cycle and its code is latched as target.
  - Pointer moves to the other requester after any grant.
  - Latched target ≠ cfg_mirr → RAMP.
  - Latched target == cfg_mirr → stay in SETTLED and pulse done on the cycle after gnt (no dwell).

Timing example:
- en sampled at edge N → RAMP at N+1.
- With DEFAULT_CODE=01 and HOLD_CYC=16: cfg_mirr=01 at edge N+17; settled=1 and done at edge N+33.

Rules:
- req is ignored (no gnt) in OFF, RAMP and RAMPDN. The requester keeps req asserted.
- Simultaneous req[0] and req[1] in SETTLED: pointer decides. Exactly one gnt.
- en=0 sampled in RAMP or SETTLED → RAMPDN with target=00 and counter cleared. en=0 takes priority over a same-cycle req (no gnt).
- en=1 sampled in RAMPDN → RAMP with target=DEFAULT_CODE, counter cleared, starting from the current cfg_mirr.
- en=0 in OFF: no effect. en=0 in RAMPDN: continue.
- cfg_mirr is always in 00..11. A step never skips a code, so 00→11 takes 3 steps.
- rst mid-ramp: cfg_mirr returns to 00 immediately. Any pending target is discarded.
- done and gnt never assert in the same cycle.

Optional Feature:
Macro CM_CTRL_STAT_EN.
- Defined: adds output reconf_cnt [7:0].
  - Counts grants whose target differed from cfg_mirr; saturates at 255.
  - Reset to 0 by rst only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Power-up, HOLD_CYC=16: rst pulse, then en=1 at edge 0 → cfg_mirr=01 at edge 17; settled=1 and done=1 at edge 33; busy=1 for edges 1..32.
- Ramp up from SETTLED@01: req[1]=1 with req_code1=11 → gnt=10 for one cycle; cfg_mirr 01→10→11 at 16-cycle spacing; done 16 cycles after code 11 is reached.
- Simultaneous requests: in SETTLED, req=11 (codes 00 and 10) → gnt=01 first, cfg_mirr goes to 00. After done, gnt=10 and cfg_mirr goes to 10. Check the pointer alternates on the next pair.
- Same-code request: in SETTLED@01, req[0]=1 with code 01 → gnt=01, done the next cycle, cfg_mirr unchanged, busy stays 0.
- Disable and re-enable: en=0 at cfg_mirr=11 → RAMPDN stepping 11→10. en=1 while at 10 → RAMP toward 01, then SETTLED. en=0 with req high in the same cycle → no gnt.
- Async reset mid-ramp: assert rst between clock edges during RAMP → cfg_mirr=00, busy=0 immediately; with CM_CTRL_STAT_EN, reconf_cnt=0.
